// File: rtl/vga_pkg.sv
// Shared VGA timing constants, VRAM geometry and arbiter state encoding.
package vga_pkg;

    localparam int unsigned H_VISIBLE      = 640;
    localparam int unsigned V_VISIBLE      = 480;
    localparam int unsigned H_TOTAL        = 800;
    localparam int unsigned V_TOTAL        = 525;
    localparam int unsigned WORDS_PER_LINE = 160;
    localparam int unsigned ADDR_W         = 17;

    // 4-pixel groups per line: visible and total
    localparam int unsigned GROUPS_VISIBLE = H_VISIBLE / 4;
    localparam int unsigned GROUPS_TOTAL   = H_TOTAL / 4;

    // VRAM owner for the current clock
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DISP_RD = 2'd1,
        CPU_RD  = 2'd2,
        CPU_WR  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/vram_addr_gen.sv
// Maps a (line, group) pair to its 17-bit VRAM word address.
module vram_addr_gen
    import vga_pkg::*;
(
    input  logic [9:0]        line_idx,
    input  logic [7:0]        group_idx,
    output logic [ADDR_W-1:0] addr
);

    // line*160 + group, with line*160 built as line*128 + line*32
    always_comb begin
        addr = ({7'd0, line_idx} << 7) + ({7'd0, line_idx} << 5) + {9'd0, group_idx};
    end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display prefetch has priority, CPU gets the
// remaining clocks with a one-clock acknowledge; also serialises the
// prefetched words into 4-bit pixel colours.
module vram_arbiter
    import vga_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        sub_pixel_counter,
    input  logic [9:0]        pixel_counter,
    input  logic [9:0]        line_counter,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [15:0]       cpu_wdata,
    output logic              cpu_ack,
    output logic [15:0]       cpu_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    output logic [3:0]        pix_color
);

    arb_state_e        state_q, state_d;
    logic [15:0]       prefetch_q, prefetch_d;
    logic              pf_valid_q, pf_valid_d;
    logic [15:0]       active_q, active_d;
    logic [3:0]        pix_q, pix_d;

    logic [7:0]        grp;
    logic              group_start;
    logic              visible;
    logic [9:0]        tgt_line;
    logic [7:0]        tgt_grp;
    logic              tgt_ok;
    logic              fetch_cycle;
    logic              cpu_busy;
    logic [ADDR_W-1:0] fetch_addr;

    // Decide whether this clock is a display fetch and which group it targets
    always_comb begin
        grp         = pixel_counter[9:2];
        group_start = (sub_pixel_counter == 2'd0) && (pixel_counter[1:0] == 2'd0);
        visible     = (pixel_counter < 10'(H_VISIBLE)) && (line_counter < 10'(V_VISIBLE));
        tgt_line    = line_counter;
        tgt_grp     = grp + 8'd1;
        tgt_ok      = 1'b0;
        if ((grp < 8'(GROUPS_VISIBLE - 1)) && (line_counter < 10'(V_VISIBLE))) begin
            tgt_ok = 1'b1;
        end else if (grp == 8'(GROUPS_TOTAL - 1)) begin
            // last group of a line prefetches group 0 of the next displayed line
            tgt_grp = '0;
            if (line_counter < 10'(V_VISIBLE - 1)) begin
                tgt_line = line_counter + 10'd1;
                tgt_ok   = 1'b1;
            end else if (line_counter == 10'(V_TOTAL - 1)) begin
                tgt_line = '0;
                tgt_ok   = 1'b1;
            end
        end
        fetch_cycle = group_start && tgt_ok;
    end

    vram_addr_gen u_addr_gen (
        .line_idx  (tgt_line),
        .group_idx (tgt_grp),
        .addr      (fetch_addr)
    );

    // Pick this clock's VRAM owner and drive the memory command
    always_comb begin
        cpu_busy = (state_q == CPU_RD) || (state_q == CPU_WR);
        state_d  = IDLE;
        if (!reset) begin
            if (fetch_cycle) begin
                state_d = DISP_RD;
            end else if (cpu_req && !cpu_busy) begin
                state_d = cpu_we ? CPU_WR : CPU_RD;
            end
        end
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (state_d)
            DISP_RD: mem_addr = fetch_addr;
            CPU_RD:  mem_addr = cpu_addr;
            CPU_WR: begin
                mem_addr  = cpu_addr;
                mem_we    = 1'b1;
                mem_wdata = cpu_wdata;
            end
            default: ;
        endcase
        // acknowledge is the clock after a CPU grant; reset abandons it
        cpu_ack   = cpu_busy && !reset;
        cpu_rdata = ((state_q == CPU_RD) && !reset) ? mem_rdata : '0;
    end

    // Prefetch capture, group load and pixel nibble selection
    always_comb begin
        prefetch_d = prefetch_q;
        pf_valid_d = pf_valid_q;
        active_d   = active_q;
        if (group_start && visible) begin
            active_d   = pf_valid_q ? prefetch_q : '0;
            pf_valid_d = 1'b0;
        end
        if (state_q == DISP_RD) begin
            prefetch_d = mem_rdata;
            pf_valid_d = 1'b1;
        end
        case (pixel_counter[1:0])
            2'd0:    pix_d = active_d[15:12];
            2'd1:    pix_d = active_d[11:8];
            2'd2:    pix_d = active_d[7:4];
            default: pix_d = active_d[3:0];
        endcase
        if (!visible) begin
            pix_d = '0;
        end
        pix_color = pix_q;
    end

    // State and display registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            prefetch_q <= '0;
            pf_valid_q <= 1'b0;
            active_q   <= '0;
            pix_q      <= '0;
        end else begin
            state_q    <= state_d;
            prefetch_q <= prefetch_d;
            pf_valid_q <= pf_valid_d;
            active_q   <= active_d;
            pix_q      <= pix_d;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: directed stimulus pushes cycle-stamped
// expectations; a negedge monitor pops and compares them.
module tb_vram_arbiter;

    localparam int K_PIX  = 0;
    localparam int K_ADDR = 1;
    localparam int K_WE   = 2;
    localparam int K_WD   = 3;
    localparam int K_ACK  = 4;
    localparam int K_RD   = 5;

    typedef struct {
        int          cyc;
        int          kind;
        logic [16:0] val;
    } exp_t;

    typedef struct {
        int          cyc;
        logic [15:0] rdata;
        bit          chk;
    } ack_t;

    logic        clk;
    logic        reset;
    logic [1:0]  sub_pixel_counter;
    logic [9:0]  pixel_counter;
    logic [9:0]  line_counter;
    logic        cpu_req;
    logic        cpu_we;
    logic [16:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_ack;
    logic [15:0] cpu_rdata;
    logic [16:0] mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic [3:0]  pix_color;

    logic [15:0] vram [0:131071];

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t expq[$];
    ack_t ackq[$];

    vram_arbiter dut (
        .clk               (clk),
        .reset             (reset),
        .sub_pixel_counter (sub_pixel_counter),
        .pixel_counter     (pixel_counter),
        .line_counter      (line_counter),
        .cpu_req           (cpu_req),
        .cpu_we            (cpu_we),
        .cpu_addr          (cpu_addr),
        .cpu_wdata         (cpu_wdata),
        .cpu_ack           (cpu_ack),
        .cpu_rdata         (cpu_rdata),
        .mem_addr          (mem_addr),
        .mem_we            (mem_we),
        .mem_wdata         (mem_wdata),
        .mem_rdata         (mem_rdata),
        .pix_color         (pix_color)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // VRAM model: synchronous write, one-clock read latency
    always @(posedge clk) begin
        if (mem_we) vram[mem_addr] <= mem_wdata;
        mem_rdata <= vram[mem_addr];
    end

    function automatic string kname(input int k);
        case (k)
            K_PIX:   return "pix_color";
            K_ADDR:  return "mem_addr";
            K_WE:    return "mem_we";
            K_WD:    return "mem_wdata";
            K_ACK:   return "cpu_ack";
            default: return "cpu_rdata";
        endcase
    endfunction

    // Monitor: CPU acks against the ack queue, cycle-stamped levels against expq
    always @(negedge clk) begin
        exp_t        e;
        ack_t        a;
        logic [16:0] act;
        if (cpu_ack === 1'b1) begin
            checks++;
            if (ackq.size() == 0) begin
                errors++;
                $display("FAIL spurious_ack cycle=%0d got cpu_ack=1 required 0", cyc);
            end else begin
                a = ackq.pop_front();
                if (a.cyc != cyc) begin
                    errors++;
                    $display("FAIL ack_timing got cycle %0d required cycle %0d", cyc, a.cyc);
                end
                if (a.chk) begin
                    checks++;
                    if (cpu_rdata !== a.rdata) begin
                        errors++;
                        $display("FAIL ack_rdata cycle=%0d got %h required %h", cyc, cpu_rdata, a.rdata);
                    end
                end
            end
        end
        while (expq.size() > 0 && expq[0].cyc <= cyc) begin
            e = expq.pop_front();
            checks++;
            if (e.cyc < cyc) begin
                errors++;
                $display("FAIL missed_%s stamped cycle %0d not sampled", kname(e.kind), e.cyc);
            end else begin
                case (e.kind)
                    K_PIX:   act = {13'd0, pix_color};
                    K_ADDR:  act = mem_addr;
                    K_WE:    act = {16'd0, mem_we};
                    K_WD:    act = {1'b0, mem_wdata};
                    K_ACK:   act = {16'd0, cpu_ack};
                    default: act = {1'b0, cpu_rdata};
                endcase
                if (act !== e.val) begin
                    errors++;
                    $display("FAIL %s cycle=%0d got %h required %h", kname(e.kind), cyc, act, e.val);
                end
            end
        end
    end

    task automatic expect_at(input int c, input int k, input logic [16:0] v);
        exp_t e;
        int   i;
        e.cyc  = c;
        e.kind = k;
        e.val  = v;
        i = expq.size();
        while (i > 0 && expq[i-1].cyc > c) i--;
        expq.insert(i, e);
    endtask

    // Four pixels of a group starting at cycle sc, each held four clocks
    task automatic expect_word(input int sc, input logic [15:0] w);
        for (int q = 0; q < 4; q++) begin
            for (int s = 0; s < 4; s++) begin
                expect_at(sc + 4*q + s + 1, K_PIX, {13'd0, w[15-4*q -: 4]});
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (sub_pixel_counter == 2'd3) begin
            if (pixel_counter == 10'd799) begin
                pixel_counter = 10'd0;
                line_counter  = (line_counter == 10'd524) ? 10'd0 : line_counter + 10'd1;
            end else begin
                pixel_counter = pixel_counter + 10'd1;
            end
        end
        sub_pixel_counter = sub_pixel_counter + 2'd1;
    endtask

    task automatic set_pos(input int l, input int p, input int s);
        line_counter      = 10'(l);
        pixel_counter     = 10'(p);
        sub_pixel_counter = 2'(s);
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    // One CPU access; delay = clocks from request to grant plus one
    task automatic cpu_op(input logic we, input logic [16:0] addr, input logic [15:0] wd,
                          input logic [15:0] exp_rd, input int delay);
        int g;
        bit seen;
        g = cyc + delay - 1;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wd;
        expect_at(g, K_ADDR, addr);
        expect_at(g, K_WE, {16'd0, we});
        if (we) expect_at(g, K_WD, {1'b0, wd});
        ackq.push_back('{g + 1, exp_rd, !we});
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            tick();
            seen = cpu_ack;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL cpu_ack_timeout addr=%h got no ack required ack within 4 clocks", addr);
        end
        tick();
        cpu_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got no completion required finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        for (int i = 0; i < 131072; i++) vram[i] = 16'h0000;
        vram[0]     = 16'hF0E1;
        vram[1]     = 16'h7777;
        vram[160]   = 16'h1234;
        vram[161]   = 16'h5678;
        vram[166]   = 16'h9ABC;
        reset     = 1'b1;
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 17'h1FFFF;
        cpu_wdata = 16'hDEAD;
        set_pos(0, 0, 0);

        // reset: fetch position and a pending write must not reach VRAM
        tick(); tick();
        set_pos(0, 0, 0);
        c = cyc;
        expect_at(c, K_ADDR, 17'd0);
        expect_at(c, K_WE, 17'd0);
        expect_at(c, K_WD, 17'd0);
        expect_at(c, K_ACK, 17'd0);
        expect_at(c, K_RD, 17'd0);
        expect_at(c, K_PIX, 17'd0);
        tick();
        reset   = 1'b0;
        cpu_req = 1'b0;

        // display: end of line 0 prefetches line 1 group 0 (word 160)
        tick();
        set_pos(0, 796, 0);
        c = cyc;
        expect_at(c, K_ADDR, 17'd160);
        expect_at(c, K_WE, 17'd0);
        expect_at(c + 1, K_PIX, 17'd0);
        expect_word(c + 16, 16'h1234);
        expect_at(c + 16, K_ADDR, 17'd161);
        expect_word(c + 32, 16'h5678);
        run_to(c + 49);

        // CPU write then read back
        set_pos(1, 9, 1);
        cpu_op(1'b1, 17'h00100, 16'hBEEF, 16'h0000, 1);
        cpu_op(1'b0, 17'h00100, 16'h0000, 16'hBEEF, 1);

        // collision: request on a fetch clock is deferred one clock
        tick();
        set_pos(1, 20, 0);
        c = cyc;
        expect_at(c, K_ADDR, 17'd166);
        expect_at(c, K_WE, 17'd0);
        expect_word(c + 16, 16'h9ABC);
        cpu_op(1'b0, 17'h00100, 16'h0000, 16'hBEEF, 2);
        run_to(c + 34);

        // fetch boundaries
        tick();
        set_pos(2, 632, 0);
        expect_at(cyc, K_ADDR, 17'd479);
        tick();
        set_pos(2, 636, 0);
        expect_at(cyc, K_ADDR, 17'd0);
        tick();
        set_pos(479, 796, 0);
        expect_at(cyc, K_ADDR, 17'd0);
        tick();

        // frame wrap: last line prefetches word 0 for line 0
        set_pos(524, 796, 0);
        c = cyc;
        expect_at(c, K_ADDR, 17'd0);
        expect_at(c, K_WE, 17'd0);
        expect_at(c + 1, K_PIX, 17'd0);
        expect_word(c + 16, 16'hF0E1);
        run_to(c + 34);

        // blanking: no display fetch, back-to-back reads every 2 clocks
        tick();
        set_pos(500, 0, 0);
        c = cyc;
        for (int i = 1; i <= 6; i++) expect_at(c + i, K_PIX, 17'd0);
        cpu_op(1'b0, 17'h00100, 16'h0000, 16'hBEEF, 1);
        cpu_op(1'b0, 17'd160, 16'h0000, 16'h1234, 1);
        cpu_op(1'b0, 17'd0, 16'h0000, 16'hF0E1, 1);

        // reset in a grant clock: no ack, prefetch discarded
        tick();
        set_pos(0, 0, 0);
        c = cyc;
        tick(); tick();
        reset     = 1'b1;
        cpu_req   = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = 17'h00100;
        expect_at(c + 3, K_ACK, 17'd0);
        expect_at(c + 3, K_RD, 17'd0);
        expect_at(c + 3, K_PIX, 17'd0);
        tick();
        reset   = 1'b0;
        cpu_req = 1'b0;
        set_pos(0, 4, 0);
        expect_word(c + 3, 16'h0000);
        run_to(c + 22);

        tick(); tick();
        checks++;
        if (ackq.size() != 0) begin
            errors++;
            $display("FAIL ack_queue got %0d pending required 0", ackq.size());
        end
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL expect_queue got %0d pending required 0", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
